// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI-slave to AXI4-Lite sequencer.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RD_PUSH
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Byte distance between consecutive words of a burst.
    function automatic int unsigned addr_step(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/spi_slave_axi_sequencer.sv
// Turns synchronized SPI-slave commands into auto-incrementing single-beat
// AXI4-Lite reads and writes while chip-select stays low.
module spi_slave_axi_sequencer
    import spi_slave_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic                        cs_sync,
    input  logic [AXI_ADDR_WIDTH-1:0]   address_sync,
    input  logic                        address_valid_sync,
    input  logic                        rd_wr_sync,
    input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rd_data,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_awaddr,
    output logic                        m_awvalid,
    input  logic                        m_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb,
    output logic                        m_wvalid,
    input  logic                        m_wready,
    input  logic [1:0]                  m_bresp,
    input  logic                        m_bvalid,
    output logic                        m_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_araddr,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]                  m_rresp,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    output logic                        busy,
    output logic [ERR_CNT_WIDTH-1:0]    err_cnt
);

    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP =
        AXI_ADDR_WIDTH'(addr_step(AXI_DATA_WIDTH));

    state_t                      state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [AXI_DATA_WIDTH-1:0]   rd_data_q;
    logic                        rd_valid_q;
    logic                        aw_done_q, w_done_q;
    logic [ERR_CNT_WIDTH-1:0]    err_cnt_q;
    logic                        aw_hs, w_hs, aw_ok, w_ok;

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // AW and W are offered together; each retires on its own handshake.
    assign m_awvalid = (state_q == ST_WR_REQ) && !aw_done_q;
    assign m_wvalid  = (state_q == ST_WR_REQ) && !w_done_q;
    assign aw_hs     = m_awvalid && m_awready;
    assign w_hs      = m_wvalid && m_wready;
    assign aw_ok     = aw_done_q || aw_hs;
    assign w_ok      = w_done_q || w_hs;

    assign wr_ready  = (state_q == ST_WR_DATA);
    assign m_bready  = (state_q == ST_WR_RESP);
    assign m_arvalid = (state_q == ST_RD_REQ);
    assign m_rready  = (state_q == ST_RD_RESP);
    assign busy      = (state_q != ST_IDLE);

    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = '1;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign err_cnt   = err_cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (address_valid_sync && !cs_sync)
                    state_d = rd_wr_sync ? ST_RD_REQ : ST_WR_DATA;
            ST_WR_DATA:
                if (cs_sync)       state_d = ST_IDLE;
                else if (wr_valid) state_d = ST_WR_REQ;
            ST_WR_REQ:
                if (aw_ok && w_ok) state_d = ST_WR_RESP;
            ST_WR_RESP:
                if (m_bvalid) state_d = cs_sync ? ST_IDLE : ST_WR_DATA;
            ST_RD_REQ:
                if (m_arready) state_d = ST_RD_RESP;
            // A read finishing after chip-select rose is thrown away.
            ST_RD_RESP:
                if (m_rvalid) state_d = cs_sync ? ST_IDLE : ST_RD_PUSH;
            ST_RD_PUSH:
                if (rd_ready)     state_d = cs_sync ? ST_IDLE : ST_RD_REQ;
                else if (cs_sync) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE:
                    if (address_valid_sync && !cs_sync) addr_q <= address_sync;
                ST_WR_DATA:
                    if (!cs_sync && wr_valid) begin
                        wdata_q   <= wr_data;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                ST_WR_REQ: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                end
                ST_WR_RESP:
                    if (m_bvalid) begin
                        addr_q <= addr_q + ADDR_STEP;
                        if (m_bresp != AXI_RESP_OKAY) err_cnt_q <= sat_inc(err_cnt_q);
                    end
                ST_RD_RESP:
                    if (m_rvalid) begin
                        addr_q <= addr_q + ADDR_STEP;
                        if (m_rresp != AXI_RESP_OKAY) err_cnt_q <= sat_inc(err_cnt_q);
                        if (!cs_sync) begin
                            rd_data_q  <= m_rdata;
                            rd_valid_q <= 1'b1;
                        end
                    end
                ST_RD_PUSH:
                    if (rd_ready || cs_sync) rd_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_axi_sequencer.sv
// Bench for spi_slave_axi_sequencer: randomized AXI slave timing and data,
// burst-level reference model of expected addresses, words and error count.
module tb_spi_slave_axi_sequencer;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_sync = 1'b1;
    logic [31:0] address_sync = '0;
    logic        address_valid_sync = 1'b0;
    logic        rd_wr_sync = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [1:0]  m_bresp = 2'b00;
    logic        m_bvalid = 1'b0;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = 2'b00;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic        busy;
    logic [7:0]  err_cnt;

    always #5 sys_clk = ~sys_clk;

    spi_slave_axi_sequencer #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .ERR_CNT_WIDTH(8)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .cs_sync(cs_sync),
        .address_sync(address_sync), .address_valid_sync(address_valid_sync),
        .rd_wr_sync(rd_wr_sync), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .busy(busy), .err_cnt(err_cnt)
    );

    int checks = 0;
    int passes = 0;

    // Reference model state: burst base and per-burst snapshots of totals.
    logic [31:0] base = '0;
    logic [31:0] wq[$];
    logic [31:0] aw_log[$];
    logic [31:0] ar_log[$];
    int aw_tot = 0, w_tot = 0, b_tot = 0, ar_tot = 0, r_tot = 0, push_tot = 0;
    int aw0 = 0, w0 = 0, b0 = 0, ar0 = 0, r0 = 0, push0 = 0;
    int err_n = 0, proto_err = 0;
    int b_issued = 0, r_issued = 0, b_err_until = 0, r_err_until = 0;
    int lat_aw = -1, lat_w = -1, lat_b = -1, lat_ar = -1, lat_r = -1;
    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    bit aw_act = 0, w_act = 0, ar_act = 0, aw_got = 0, w_got = 0;
    bit b_sched = 0, r_sched = 0, b_fire = 0, r_fire = 0, aw_lo_w_hi = 0;
    logic [31:0] r_addr = '0;
    int flush_req = 0, flush_ack = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_3C5A;
    endfunction

    function automatic int pick(input int l);
        return (l < 0) ? int'($urandom_range(0, 3)) : l;
    endfunction

    function automatic logic [7:0] sat_model(input int n);
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    // AXI slave plus compare process; runs on the falling edge.
    task mon_step();
        logic [31:0] e;
        int i;
        if (flush_req != flush_ack) begin
            flush_ack = flush_req;
            m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
            aw_act = 0; w_act = 0; ar_act = 0; aw_got = 0; w_got = 0;
            b_sched = 0; r_sched = 0; b_fire = 0; r_fire = 0; err_n = 0;
            return;
        end
        if (b_fire) m_bvalid = 0;
        if (r_fire) m_rvalid = 0;
        if (b_sched && !m_bvalid) begin
            if (b_wait > 0) b_wait--;
            else begin
                m_bvalid = 1;
                m_bresp = (b_issued < b_err_until) ? 2'b10 : 2'b00;
                b_issued++;
                b_sched = 0;
            end
        end
        if (r_sched && !m_rvalid) begin
            if (r_wait > 0) r_wait--;
            else begin
                m_rvalid = 1;
                m_rdata = mem_word(r_addr);
                m_rresp = (r_issued < r_err_until) ? 2'b11 : 2'b00;
                r_issued++;
                r_sched = 0;
            end
        end
        if ((aw_act && !m_awvalid) || (w_act && !m_wvalid) || (ar_act && !m_arvalid))
            proto_err++;
        if (m_awvalid && !aw_act) begin aw_act = 1; aw_wait = pick(lat_aw); end
        if (m_wvalid && !w_act)   begin w_act = 1;  w_wait = pick(lat_w);   end
        if (m_arvalid && !ar_act) begin ar_act = 1; ar_wait = pick(lat_ar); end
        m_awready = aw_act && (aw_wait == 0);
        m_wready  = w_act && (w_wait == 0);
        m_arready = ar_act && (ar_wait == 0);
        if (aw_wait > 0) aw_wait--;
        if (w_wait > 0)  w_wait--;
        if (ar_wait > 0) ar_wait--;
        if (!m_awvalid && m_wvalid) aw_lo_w_hi = 1;

        if (m_awvalid && m_awready) begin
            e = base + 32'(4 * (aw_tot - aw0));
            check("aw_addr", 64'(m_awaddr), 64'(e));
            aw_log.push_back(m_awaddr);
            aw_tot++; aw_act = 0; aw_got = 1;
        end
        if (m_wvalid && m_wready) begin
            i = w_tot - w0;
            e = (i < wq.size()) ? wq[i] : ~m_wdata;
            check("w_data", 64'(m_wdata), 64'(e));
            check("w_strb", 64'(m_wstrb), 64'hF);
            w_tot++; w_act = 0; w_got = 1;
        end
        if (aw_got && w_got) begin
            aw_got = 0; w_got = 0; b_sched = 1; b_wait = pick(lat_b);
        end
        b_fire = m_bvalid && m_bready;
        if (b_fire) begin
            b_tot++;
            if (m_bresp != 2'b00) err_n++;
        end
        if (m_arvalid && m_arready) begin
            e = base + 32'(4 * (ar_tot - ar0));
            check("ar_addr", 64'(m_araddr), 64'(e));
            ar_log.push_back(m_araddr);
            ar_tot++; ar_act = 0; r_sched = 1; r_wait = pick(lat_r); r_addr = m_araddr;
        end
        r_fire = m_rvalid && m_rready;
        if (r_fire) begin
            r_tot++;
            if (m_rresp != 2'b00) err_n++;
        end
        if (rd_valid && rd_ready) begin
            e = mem_word(base + 32'(4 * (push_tot - push0)));
            check("rd_data", 64'(rd_data), 64'(e));
            push_tot++;
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse(input logic [31:0] addr, input logic rd);
        address_sync = addr;
        rd_wr_sync = rd;
        address_valid_sync = 1;
        cyc();
        address_valid_sync = 0;
    endtask

    task automatic cmd(input logic [31:0] addr, input logic rd);
        base = addr;
        aw0 = aw_tot; w0 = w_tot; b0 = b_tot; ar0 = ar_tot; r0 = r_tot; push0 = push_tot;
        wq.delete();
        cs_sync = 0;
        pulse(addr, rd);
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            if (!busy) begin ok = 1; break; end
            cyc();
        end
    endtask

    task automatic wr_burst(input logic [31:0] addr, input int n);
        bit ok;
        cmd(addr, 0);
        check("wr_ready_after_cmd", 64'(wr_ready), 64'd1);
        for (int k = 0; k < n; k++) begin
            wr_data = $urandom;
            wr_valid = 1;
            for (int i = 0; i < 100 && !wr_ready; i++) cyc();
            if (wr_ready) wq.push_back(wr_data);
            cyc();
            wr_valid = 0;
        end
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (b_tot - b0 >= n) begin ok = 1; break; end
            cyc();
        end
        check("wr_b_timeout", 64'(ok), 64'd1);
        cs_sync = 1;
        wait_idle(50, ok);
        check("wr_idle", 64'(ok), 64'd1);
        check("wr_aw_count", 64'(aw_tot - aw0), 64'(n));
        check("wr_w_count", 64'(w_tot - w0), 64'(n));
        check("wr_b_count", 64'(b_tot - b0), 64'(n));
    endtask

    task automatic rd_burst(input logic [31:0] addr, input int n, input bit rnd, input int lim);
        bit ok;
        cmd(addr, 1);
        check("ar_valid_after_cmd", 64'(m_arvalid), 64'd1);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            if (push_tot - push0 >= n) begin ok = 1; break; end
            rd_ready = rnd ? 1'($urandom) : 1'b1;
            cyc();
        end
        check("rd_push_timeout", 64'(ok), 64'd1);
        cs_sync = 1;
        wait_idle(100, ok);
        check("rd_idle", 64'(ok), 64'd1);
        check("rd_ar_count", 64'(ar_tot - ar0), 64'(n + 1));
        check("rd_r_count", 64'(r_tot - r0), 64'(n + 1));
        check("rd_push_count", 64'(push_tot - push0), 64'(n));
        check("rd_valid_dropped", 64'(rd_valid), 64'd0);
        rd_ready = 0;
    endtask

    task automatic run_tests();
        bit ok;
        int snap_aw, snap_ar;

        repeat (3) cyc();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_valids", 64'({m_awvalid, m_wvalid, m_arvalid, rd_valid}), 64'd0);
        check("rst_readies", 64'({wr_ready, m_bready, m_rready}), 64'd0);
        check("rst_regs", 64'(m_awaddr | rd_data | m_wdata), 64'd0);
        rst = 0;
        cyc();

        // Write burst of three words, chip-select held.
        wr_burst(32'h0000_1000, 3);
        check("wr_addr0", 64'(aw_log[aw0]), 64'h1000);
        check("wr_addr1", 64'(aw_log[aw0 + 1]), 64'h1004);
        check("wr_addr2", 64'(aw_log[aw0 + 2]), 64'h1008);

        // Four-word read; the prefetch after the fourth completes but is dropped.
        rd_burst(32'h0000_2000, 4, 0, 200);

        // AW accepted three cycles before W.
        lat_aw = 0; lat_w = 3; lat_b = 0;
        aw_lo_w_hi = 0;
        wr_burst(32'h0000_9000, 1);
        check("aw_dropped_w_held", 64'(aw_lo_w_hi), 64'd1);
        lat_aw = -1; lat_w = -1; lat_b = -1;

        // Error responses and saturation.
        lat_aw = 0; lat_w = 0; lat_b = 0; lat_ar = 0; lat_r = 0;
        b_err_until = b_issued + 2;
        wr_burst(32'h0000_4000, 2);
        r_err_until = r_issued + 1;
        rd_burst(32'h0000_4100, 1, 0, 100);
        check("err_cnt_three", 64'(err_cnt), 64'd3);
        check("err_cnt_model", 64'(err_cnt), 64'(sat_model(err_n)));
        r_err_until = r_issued + 1000;
        rd_burst(32'h0000_8000, 297, 0, 6000);
        r_err_until = r_issued;
        check("err_cnt_sat", 64'(err_cnt), 64'd255);
        check("err_cnt_sat_model", 64'(err_cnt), 64'(sat_model(err_n)));
        lat_aw = -1; lat_w = -1; lat_b = -1; lat_ar = -1; lat_r = -1;

        // Ignored commands: chip-select high, and while busy.
        snap_aw = aw_tot; snap_ar = ar_tot;
        cs_sync = 1;
        pulse(32'h0000_7000, 0);
        repeat (3) cyc();
        check("cs_high_pulse_busy", 64'(busy), 64'd0);
        check("cs_high_pulse_axi", 64'((aw_tot - snap_aw) + (ar_tot - snap_ar)), 64'd0);
        rd_ready = 0;
        cmd(32'h0000_3000, 1);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (rd_valid) begin ok = 1; break; end
            cyc();
        end
        check("busy_pulse_rd_valid", 64'(ok), 64'd1);
        snap_aw = aw_tot;
        pulse(32'h0000_5000, 0);
        repeat (4) cyc();
        check("busy_pulse_busy", 64'(busy), 64'd1);
        check("busy_pulse_hold", 64'(rd_valid), 64'd1);
        check("busy_pulse_ar", 64'(ar_tot - ar0), 64'd1);
        check("busy_pulse_aw", 64'(aw_tot - snap_aw), 64'd0);
        cs_sync = 1;
        wait_idle(20, ok);
        check("cs_drop_idle", 64'(ok), 64'd1);
        check("cs_drop_rd_valid", 64'(rd_valid), 64'd0);
        check("cs_drop_push", 64'(push_tot - push0), 64'd0);

        // Randomized bursts.
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1)
                rd_burst($urandom & 32'hFFFF_FFFC, int'($urandom_range(1, 5)), 1, 400);
            else
                wr_burst($urandom & 32'hFFFF_FFFC, int'($urandom_range(1, 5)));
        end

        // Address wrap.
        rd_burst(32'hFFFF_FFFC, 2, 0, 200);
        check("wrap_ar0", 64'(ar_log[ar0]), 64'hFFFF_FFFC);
        check("wrap_ar1", 64'(ar_log[ar0 + 1]), 64'h0);

        // Reset while waiting for R.
        lat_ar = 0; lat_r = 30;
        cmd(32'h0000_6000, 1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_rready) begin ok = 1; break; end
            cyc();
        end
        check("rd_resp_reached", 64'(ok), 64'd1);
        rst = 1;
        cyc();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ctrl", 64'({m_rready, m_arvalid, rd_valid, m_awvalid, m_wvalid, wr_ready, m_bready}), 64'd0);
        check("midrst_err_cnt", 64'(err_cnt), 64'd0);
        check("midrst_regs", 64'(m_araddr | rd_data | m_wdata), 64'd0);
        rst = 0;
        cs_sync = 1;
        flush_req++;
        repeat (3) cyc();
        lat_ar = -1; lat_r = -1;
        check("after_rst_idle", 64'(busy), 64'd0);
        check("protocol_retract", 64'(proto_err), 64'd0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge sys_clk);
                mon_step();
            end
            begin
                run_tests();
                $display("%0d/%0d checks passed", passes, checks);
                $finish;
            end
        join_any
    end

endmodule
